// File: rtl/mult_scheduler_pkg.sv
// Shared types and constants for the multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic ID_PIPE = 1'b0;  // integer pipeline EX stage
  localparam logic ID_AUX  = 1'b1;  // secondary issue path

  localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mult_scheduler_if.sv
// Requester, multiplier and response signals of the multiplier scheduler.
// slave: scheduler side; master: requesters / multiplier / response sink side.
interface mult_scheduler_if #(
  parameter int unsigned W = 32
);
  logic           req0;
  logic [W-1:0]   a0;
  logic [W-1:0]   b0;
  logic           sgn0;
  logic           req1;
  logic [W-1:0]   a1;
  logic [W-1:0]   b1;
  logic           sgn1;
  logic           gnt0;
  logic           gnt1;
  logic           busy;
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_done;
  logic [2*W-1:0] mul_result;
  logic           rsp_valid;
  logic           rsp_id;
  logic [2*W-1:0] rsp_result;
  logic           rsp_err;

  modport slave (
    input  req0, a0, b0, sgn0, req1, a1, b1, sgn1, mul_done, mul_result,
    output gnt0, gnt1, busy, mul_start, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport master (
    output req0, a0, b0, sgn0, req1, a1, b1, sgn1, mul_done, mul_result,
    input  gnt0, gnt1, busy, mul_start, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/mult_scheduler_rr_arb2.sv
// Two-way combinational round-robin picker: a lone requester always wins,
// on a tie the requester that was not granted last wins.
module rr_arb2
  import mult_sched_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic id
);

  // Winner selection
  always_comb begin
    valid = req0 | req1;
    id    = ID_PIPE;
    if (req0 && req1) begin
      id = ~last_grant;
    end else if (req1) begin
      id = ID_AUX;
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// Arbitration and sequencing controller for the shared W x W -> 2W
// multi-cycle multiplier, with a WAIT-state watchdog.
// Optional signed support: define MULT_SCHED_SIGNED_EN.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,  // 1..255
  parameter int unsigned W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  mult_scheduler_if.slave  bus
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic           last_grant_q;
  logic [7:0]     timer_q;
  logic [W-1:0]   op_a_q, op_b_q;
  logic           id_q;
  logic [2*W-1:0] rsp_result_q;
  logic           rsp_id_q;
  logic           rsp_err_q;

  logic           arb_valid, arb_id;
  logic [W-1:0]   sel_a, sel_b, mag_a, mag_b;
  logic [2*W-1:0] prod;
  logic           timeout_hit;

  logic           gnt0_c, gnt1_c, busy_c, start_c, rsp_valid_c;

`ifdef MULT_SCHED_SIGNED_EN
  logic           sel_sgn;
  logic           neg_d, neg_q;
`endif

  rr_arb2 u_arb (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .id         (arb_id)
  );

  // Operands of the requester about to be granted (magnitudes in signed mode)
  always_comb begin
    sel_a = bus.a0;
    sel_b = bus.b0;
    if (arb_id == ID_AUX) begin
      sel_a = bus.a1;
      sel_b = bus.b1;
    end
`ifdef MULT_SCHED_SIGNED_EN
    sel_sgn = (arb_id == ID_AUX) ? bus.sgn1 : bus.sgn0;
    // The most negative value negates to itself, which read unsigned is its magnitude
    mag_a   = (sel_sgn && sel_a[W-1]) ? -sel_a : sel_a;
    mag_b   = (sel_sgn && sel_b[W-1]) ? -sel_b : sel_b;
    neg_d   = sel_sgn && (sel_a[W-1] ^ sel_b[W-1]);
`else
    mag_a = sel_a;
    mag_b = sel_b;
`endif
  end

`ifdef MULT_SCHED_SIGNED_EN
  // Negating a zero product yields zero, so no separate nonzero test is needed
  assign prod = neg_q ? -bus.mul_result : bus.mul_result;
`else
  assign prod = bus.mul_result;
`endif

  assign timeout_hit = (timer_q == TIMER_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d     = state_q;
    gnt0_c      = 1'b0;
    gnt1_c      = 1'b0;
    start_c     = 1'b0;
    rsp_valid_c = 1'b0;
    busy_c      = (state_q != IDLE);
    unique case (state_q)
      IDLE:  if (arb_valid) state_d = ISSUE;
      ISSUE: begin
        gnt0_c  = (id_q == ID_PIPE);
        gnt1_c  = (id_q == ID_AUX);
        start_c = 1'b1;
        state_d = WAIT;
      end
      WAIT:  if (bus.mul_done || timeout_hit) state_d = RESP;
      RESP: begin
        rsp_valid_c = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latches, round-robin history, watchdog timer and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= ID_AUX;
      timer_q      <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      id_q         <= ID_PIPE;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
`ifdef MULT_SCHED_SIGNED_EN
      neg_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (arb_valid) begin
          op_a_q    <= mag_a;
          op_b_q    <= mag_b;
          id_q      <= arb_id;
          rsp_err_q <= 1'b0;
`ifdef MULT_SCHED_SIGNED_EN
          neg_q     <= neg_d;
`endif
        end
        ISSUE: begin
          last_grant_q <= id_q;
          timer_q      <= '0;
        end
        WAIT: begin
          timer_q <= timer_q + 8'd1;
          // done takes priority over a coincident timeout
          if (bus.mul_done) begin
            rsp_result_q <= prod;
            rsp_id_q     <= id_q;
            rsp_err_q    <= 1'b0;
          end else if (timeout_hit) begin
            rsp_result_q <= '0;
            rsp_id_q     <= id_q;
            rsp_err_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0       = gnt0_c;
  assign bus.gnt1       = gnt1_c;
  assign bus.busy       = busy_c;
  assign bus.mul_start  = start_c;
  assign bus.mul_a      = op_a_q;
  assign bus.mul_b      = op_b_q;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: doc/mult_scheduler.md
Name: mult_scheduler

Overview:
- Arbitration and sequencing controller for the shared 32x32->64 multi-cycle multiplier.
- Accepts multiply requests from two requesters: port 0 is the integer pipeline EX stage, port 1 is the secondary issue path.
- Grants one requester at a time (round-robin), drives the multiplier's start pulse and operands, waits for its done pulse, and returns the 64-bit product tagged with the requester ID.
- A watchdog aborts a hung operation and returns an error response instead.

Parameters:
TIMEOUT, 16, WAIT-state cycles allowed before abort; legal range 1..255
W, 32, operand width; product width is 2*W

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high; one clock and one reset, polarity and synchronicity fixed
req0  input  1  requester 0 request; held high until gnt0
a0  input  W  requester 0 operand A
b0  input  W  requester 0 operand B
sgn0  input  1  requester 0 signed-operation flag
req1  input  1  requester 1 request; held high until gnt1
a1  input  W  requester 1 operand A
b1  input  W  requester 1 operand B
sgn1  input  1  requester 1 signed-operation flag
gnt0  output  1  one-cycle grant pulse to requester 0
gnt1  output  1  one-cycle grant pulse to requester 1
busy  output  1  high whenever state is not IDLE
mul_start  output  1  one-cycle start pulse to the multiplier
mul_a  output  W  operand A to multiplier, held stable from ISSUE through WAIT
mul_b  output  W  operand B to multiplier, held stable from ISSUE through WAIT
mul_done  input  1  multiplier completion pulse
mul_result  input  2W  multiplier product, valid when mul_done is high
rsp_valid  output  1  one-cycle response pulse
rsp_id  output  1  requester the response belongs to
rsp_result  output  2W  product; 0 on error
rsp_err  output  1  timeout abort flag, qualified by rsp_valid

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0; last_grant=1, so requester 0 wins the first tie; timer=0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is high, pick the winner, latch its operands, sign flag and ID, go to ISSUE.
  - Otherwise stay in IDLE.
  - Round-robin: a single requester always wins; if both request, the one not equal to last_grant wins.
- ISSUE (exactly 1 cycle):
  - gnt<id>=1, mul_start=1, mul_a/mul_b driven from the latched values.
  - last_grant<=id; timer<=0; go to WAIT.
- WAIT:
  - mul_start=0; timer increments each cycle.
  - If mul_done=1: latch mul_result and go to RESP.
  - Else if timer==TIMEOUT-1: set the error flag and go to RESP.
  - If mul_done and the timeout coincide, mul_done wins (no error).
- RESP (exactly 1 cycle):
  - rsp_valid=1; rsp_id, rsp_result and rsp_err valid; go to IDLE.
  - rsp_result/rsp_id hold their values after RESP until the next RESP; rsp_err is cleared on the next ISSUE.
- Latency: req sampled in IDLE at cycle t -> gnt/mul_start at t+1 -> done sampled at WAIT cycle w -> rsp_valid at w+1.
- Back-to-back: minimum spacing between grants is 4 cycles. A request arriving during ISSUE, WAIT or RESP waits for IDLE.
- Requester protocol: the requester keeps req and operands stable until it sees gnt, and drops req the following cycle. Operands are sampled only at the IDLE->ISSUE edge.
- mul_done outside WAIT is ignored.
- Reset mid-operation: immediate return to IDLE, no response is emitted, pending requests are re-arbitrated after reset deasserts. The multiplier shares the same reset.
- Unsigned arithmetic by default: mul_a=a, mul_b=b, rsp_result=mul_result.

Optional Feature:
MULT_SCHED_SIGNED_EN
- Defined:
  - When the latched sgn=1, mul_a/mul_b carry the magnitudes |a| and |b|; 0x80000000 maps to 0x80000000 unsigned.
  - The product is two's-complement negated (2W bits) if sign(a) XOR sign(b) and the product is nonzero.
  - The negation is applied when latching in WAIT, so latency is unchanged.
  - sgn=0 behaves unsigned.
- Undefined: sgn0/sgn1 are ignored; all operations are unsigned.

Decomposition:
- Package mult_sched_pkg: state encoding constants (IDLE=0, ISSUE=1, WAIT=2, RESP=3), requester ID constants (ID_PIPE=0, ID_AUX=1), default TIMEOUT.
- Sub-module rr_arb2: combinational two-way round-robin picker with inputs req0, req1, last_grant and outputs valid, id.
- The FSM, operand latches, timer and sign logic stay in mult_scheduler.

Test Plan:
- Single request: req0 with a0=3, b0=5 at cycle 0; model multiplier asserts done 4 cycles after start -> gnt0 and mul_start at cycle 1, rsp_valid at cycle 6, rsp_id=0, rsp_result=15, rsp_err=0.
- Contention: req0 and req1 both high from reset, each held until granted -> gnt0 first, then gnt1 after the first RESP; with both requesters re-requesting, grants alternate 0,1,0,1.
- Timeout: TIMEOUT=16, model never asserts done -> rsp_valid 17 cycles after ISSUE with rsp_err=1 and rsp_result=0; busy drops the following cycle.
- Coincident done and timeout: done on the last WAIT cycle -> rsp_err=0 with the correct product.
- Reset mid-WAIT: assert reset for 1 cycle -> no rsp_valid, all outputs 0, a still-pending req1 is granted 1 cycle after reset deasserts.
- Signed (MULT_SCHED_SIGNED_EN): a=0xFFFFFFFE (-2), b=3, sgn=1 -> mul_a=2, rsp_result=0xFFFFFFFFFFFFFFFA; a=0x80000000, b=1 -> 0xFFFFFFFF80000000.
